// File: rtl/w3_pkg.sv
// Shared definitions for the w3 weight banks: geometry, loader states and
// the signed weight type seen by both the loader and the w3 consumer.
package w3_pkg;
    localparam int NBANK   = 16;
    localparam int DEPTH   = 16;
    localparam int WADDR_W = 4;
    localparam int WDATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic signed [WDATA_W-1:0] weight_t;
endpackage

// File: rtl/w3_loader_cksum.sv
// Checksum accumulator/comparator for the weight loader. Sums the unsigned
// value of every weight byte modulo 2^16, captures the two trailing checksum
// bytes (low then high) and flags a mismatch when the high byte arrives.
module w3_loader_cksum
    import w3_pkg::*;
(
    input  logic               clk,
    input  logic               xrst,
    input  logic               clr,
    input  logic               acc_en,
    input  logic               ck_en,
    input  logic               ck_hi,
    input  logic [WDATA_W-1:0] data,
    output logic               err
);
    logic [15:0]        sum_q;
    logic [WDATA_W-1:0] lo_q;
    logic               err_q;

    // Running sum, captured low byte, and sticky mismatch flag.
    always_ff @(posedge clk) begin
        if (xrst || clr) begin
            sum_q <= '0;
            lo_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (acc_en) begin
                sum_q <= sum_q + {8'd0, data};
            end
            if (ck_en && !ck_hi) begin
                lo_q <= data;
            end
            if (ck_en && ck_hi) begin
                err_q <= ({data, lo_q} != sum_q);
            end
        end
    end

    assign err = err_q;
endmodule

// File: rtl/w3_loader.sv
// Weight bank loader: takes a valid/ready byte stream and writes it
// address-major into NBANK banks of DEPTH entries each. One load per start.
// Optional trailing checksum is enabled by defining W3_LOADER_CHECKSUM_EN.
module w3_loader #(
    parameter int NBANK = w3_pkg::NBANK,
    parameter int DEPTH = w3_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     start,
    output logic                     finish,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    output logic [NBANK-1:0]         w_we,
    output logic [$clog2(DEPTH)-1:0] w_waddr,
    output w3_pkg::weight_t          w_wdata,
    output logic                     err
);
    import w3_pkg::*;

    localparam int BANK_W = $clog2(NBANK);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = BANK_W + ADDR_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBANK * DEPTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBANK-1:0] w_we_q;
    logic [ADDR_W-1:0] w_waddr_q;
    weight_t          w_wdata_q;
    logic [NBANK-1:0] we_dec;
    logic             accept;
    logic             write_en;
    logic             start_acc;

    assign accept    = in_valid && in_ready;
    assign write_en  = accept && (state_q == LOAD);
    assign start_acc = start && (state_q == IDLE);

    // Low bits of the byte counter select the bank.
    genvar gi;
    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_dec
            assign we_dec[gi] = (cnt_q[BANK_W-1:0] == BANK_W'(gi));
        end
    endgenerate

    // State and byte counter registers.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter wraps to zero after the last weight so
    // its bit 0 then tells the two checksum bytes apart.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
`ifdef W3_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q[0]) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered write port: strobe one cycle after acceptance, zero otherwise.
    always_ff @(posedge clk) begin
        if (xrst) begin
            w_we_q    <= '0;
            w_waddr_q <= '0;
            w_wdata_q <= '0;
        end else begin
            w_we_q <= write_en ? we_dec : '0;
            if (write_en) begin
                w_waddr_q <= cnt_q[CNT_W-1:BANK_W];
                w_wdata_q <= weight_t'(in_data);
            end
        end
    end

    assign w_we     = w_we_q;
    assign w_waddr  = w_waddr_q;
    assign w_wdata  = w_wdata_q;
    assign in_ready = (state_q == LOAD) || (state_q == CHK);
    assign busy     = (state_q != IDLE);
    assign finish   = (state_q == DONE);

`ifdef W3_LOADER_CHECKSUM_EN
    w3_loader_cksum u_cksum (
        .clk    (clk),
        .xrst   (xrst),
        .clr    (start_acc),
        .acc_en (write_en),
        .ck_en  (accept && (state_q == CHK)),
        .ck_hi  (cnt_q[0]),
        .data   (in_data),
        .err    (err)
    );
`else
    assign err = 1'b0;
    logic unused_ok;
    assign unused_ok = start_acc;
`endif
endmodule
